// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_seq_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DW         = 2 * XLEN;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the CPU pipeline and the multiply/divide unit.
interface muldiv_seq_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic          is_div_i,
    input  logic [DW-1:0] acc_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [DW-1:0] acc_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] diff;
    logic            ge;

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits then quotient bits}.
    always_comb begin
        sum   = {1'b0, acc_i[DW-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem   = {acc_i[DW-1:XLEN], acc_i[XLEN-1]};
        ge    = rem >= {1'b0, opnd_i};
        diff  = rem[XLEN-1:0] - opnd_i;
        acc_o = {sum, acc_i[XLEN-1:1]};
        if (is_div_i) begin
            acc_o = ge ? {diff, acc_i[XLEN-2:0], 1'b1}
                       : {rem[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide unit: 32 single-bit steps plus a sign-fix cycle.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);

    localparam logic [XLEN-1:0] DIV0_LO = '1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    acc_q;
    logic [XLEN-1:0]  opnd_q;
    logic             sa_q;
    logic             sb_q;
    logic             is_div_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic             busy_q;
    logic             done_q;

    op_e              op_c;
    logic             is_div_c;
    logic             is_signed_c;
    logic             sa_c;
    logic             sb_c;
    logic [XLEN-1:0]  abs_a_c;
    logic [XLEN-1:0]  abs_b_c;
    logic [DW-1:0]    prod_c;
    logic [XLEN-1:0]  quo_c;
    logic [XLEN-1:0]  rem_c;
    logic [DW-1:0]    step_acc;

    // Operand decode on the request side, sign fix-up on the result side.
    always_comb begin
        op_c        = op_e'(bus.op);
        is_div_c    = (op_c == OP_DIV) || (op_c == OP_DIVU);
        is_signed_c = (op_c == OP_MUL) || (op_c == OP_DIV);
        sa_c        = is_signed_c & bus.a[XLEN-1];
        sb_c        = is_signed_c & bus.b[XLEN-1];
        abs_a_c     = cond_neg(bus.a, sa_c);
        abs_b_c     = cond_neg(bus.b, sb_c);
        prod_c      = (sa_q ^ sb_q) ? (~acc_q + DW'(1)) : acc_q;
        quo_c       = cond_neg(acc_q[XLEN-1:0], sa_q ^ sb_q);
        rem_c       = cond_neg(acc_q[DW-1:XLEN], sa_q);
    end

    muldiv_step u_step (
        .is_div_i (state_q == S_DIV),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        cnt_q    <= '0;
                        sa_q     <= sa_c;
                        sb_q     <= sb_c;
                        is_div_q <= is_div_c;
                        busy_q   <= 1'b1;
                        if (is_div_c && (bus.b == '0)) begin
                            // Divide by zero bypasses the datapath entirely.
                            hi_q    <= bus.a;
                            lo_q    <= DIV0_LO;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (is_div_c) begin
                            acc_q   <= {{XLEN{1'b0}}, abs_a_c};
                            opnd_q  <= abs_b_c;
                            state_q <= S_DIV;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, abs_b_c};
                            opnd_q  <= abs_a_c;
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (bus.cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= step_acc;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            hi_q <= rem_c;
                            lo_q <= quo_c;
                        end else begin
                            hi_q <= prod_c[DW-1:XLEN];
                            lo_q <= prod_c[XLEN-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: arithmetic reference model plus directed corner cases.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb_q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference results straight from signed/unsigned 64-bit arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        lat = 34;
        p   = '0;
        if (op[1] && b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            lat = 1;
        end else begin
            case (op_e'(op))
                OP_MUL:  p = 64'(sa * sbv);
                OP_MULU: p = {32'd0, a} * {32'd0, b};
                OP_DIV:  p = {32'(sa % sbv), 32'(sa / sbv)};
                default: p = {a % b, a / b};
            endcase
            hi = p[63:32];
            lo = p[31:0];
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done, input bit with_cancel);
        int          guard;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        exp_t        e;
        guard = 0;
        while (bus.busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy !== 1'b0) check("idle_wait", 64'(bus.busy), 64'd0);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        bus.cancel = with_cancel;
        model(op, a, b, hi, lo, lat);
        if (expect_done) begin
            // Accepting edge is cyc+1; done is visible during the lat-th cycle after it.
            e.hi  = hi;
            e.lo  = lo;
            e.cyc = cyc + lat;
            sb_q.push_back(e);
            last_hi = hi;
            last_lo = lo;
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got hi=%h lo=%h with no request pending", bus.hi, bus.lo);
            end else begin
                e = sb_q.pop_front();
                check("hi", 64'(bus.hi), 64'(e.hi));
                check("lo", 64'(bus.lo), 64'(e.lo));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          guard;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = '0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        issue(OP_DIVU, 32'd7, 32'd0, 1'b1, 1'b0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(OP_DIV, 32'h8000_0000, 32'd0, 1'b1, 1'b0);

        // start while busy must be ignored
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULU;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_mid_div", 64'(bus.busy), 64'd1);

        // cancel mid-multiply: no done, busy drops, results held
        issue(OP_MULU, 32'd6, 32'd7, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", 64'(bus.busy), 64'd0);
        check("cancel_hi", 64'(bus.hi), 64'(last_hi));
        check("cancel_lo", 64'(bus.lo), 64'(last_lo));
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1, 1'b0);

        // reset mid-divide discards the operation and clears results
        issue(OP_DIV, 32'd1000, 32'd7, 1'b0, 1'b0);
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (14 - ((guard > 14) ? 14 : guard)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_hi", 64'(bus.hi), 64'd0);
        check("midrst_lo", 64'(bus.lo), 64'd0);
        last_hi = '0;
        last_lo = '0;
        issue(OP_MUL, 32'd2, 32'd2, 1'b1, 1'b0);

        // start and cancel together in IDLE: start wins
        issue(OP_MULU, 32'd12345, 32'd678, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            issue(op, a, b, 1'b1, 1'b0);
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 op  input  2  operation, equal to funct[1:0]: 00 mul (signed), 01 mulu, 10 div (signed), 11 divu.
REQ-005 a  input  32  multiplicand / dividend (rs); captured on accepted start.
REQ-006 b  input  32  multiplier / divisor (rt); captured on accepted start.
REQ-007 cancel  input  1  abort in-flight operation.
REQ-008 busy  output  1  high in every state except IDLE; drives the CPU pipeline stall.
REQ-009 done  output  1  one-cycle pulse when hi/lo become valid.
REQ-010 hi  output  32  mul: product[63:32]; div: remainder.
REQ-011 lo  output  32  mul: product[31:0]; div: quotient.

Function
REQ-012 FSM states: IDLE, MUL, DIV, FIX, DONE; one-hot or binary encoding at implementer's choice.
REQ-013 IDLE with start=1: capture operands, step counter := 0, next state MUL (op[1]=0) or DIV (op[1]=1).
REQ-014 Signed ops (op[0]=0): operate on |a| and |b| as unsigned 32-bit values; record sa=a[31], sb=b[31]. Unsigned ops: sa=sb=0.
REQ-015 MUL: one shift-add step per cycle, 64-bit accumulator, exactly 32 cycles, then FIX.
REQ-016 DIV: one restoring shift-subtract step per cycle (33-bit partial remainder), exactly 32 cycles, then FIX.
REQ-017 FIX (1 cycle): mul negates 64-bit product if sa^sb; div negates quotient if sa^sb and remainder if sa; writes hi/lo; next state DONE.
REQ-018 DONE (1 cycle): done=1, busy=1; next state IDLE.
REQ-019 Latency: accepted start at edge N -> done high in the cycle after edge N+34; busy high for cycles N+1..N+34.
REQ-020 Divide by zero (b=0, div/divu): skip DIV/FIX; IDLE -> DONE directly; hi := a, lo := 32'hFFFFFFFF; done in the cycle after edge N+1.
REQ-021 div 0x80000000 / 0xFFFFFFFF: lo := 0x80000000, hi := 0 (two's-complement wrap, no trap).
REQ-022 start while busy=1: ignored; no re-capture, no effect on the running operation.
REQ-023 cancel=1 in MUL/DIV/FIX: next state IDLE; hi/lo keep previous values; no done pulse. cancel in IDLE/DONE: no effect.
REQ-024 start and cancel both high in IDLE: start accepted.
REQ-025 hi/lo change only in FIX, in the divide-by-zero transition, or on reset; otherwise hold.

Reset
REQ-026 rst=1: state := IDLE, hi := 0, lo := 0, counter := 0, busy=0, done=0, on the next edge.
REQ-027 rst overrides start and cancel, including mid-operation; the operation is discarded.

Structure
REQ-028 Shared package holds op encodings (OP_MUL, OP_MULU, OP_DIV, OP_DIVU), state encodings and ITER_COUNT=32.
REQ-029 One sub-module, muldiv_step: combinational single-iteration shift-add / shift-subtract; the FSM, counter and registers stay in muldiv_seq.
REQ-030 Target size 150-300 lines of RTL; no multiplier or divider operators inferred.

Verification
REQ-031 mulu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after start.
REQ-032 mul a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 divu a=7 b=0 -> done after 1 busy cycle, hi=0x00000007, lo=0xFFFFFFFF; div 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-034 divu 100/7 started; start with mulu 2*3 pulsed at cycle 10 -> ignored; result hi=2, lo=14.
REQ-035 mulu 6*7 cancelled at cycle 20 -> no done, busy low next cycle, hi/lo unchanged; following divu 9/3 -> lo=3, hi=0.
REQ-036 rst asserted at cycle 15 of a div -> next cycle busy=0, done=0, hi=lo=0; subsequent mul 2*2 -> lo=4.
